// File: rtl/cluster_icache_perf_pkg.sv
// Register offsets, control bit positions and event numbering of the icache performance block.
package cluster_icache_perf_pkg;

    localparam logic [31:0] REG_CTRL        = 32'h000;
    localparam logic [31:0] REG_FLUSH       = 32'h004;
    localparam logic [31:0] REG_SEL_FLUSH   = 32'h008;
    localparam logic [31:0] REG_CLEAR       = 32'h00C;
    localparam logic [31:0] REG_OVERFLOW_LO = 32'h010;
    localparam logic [31:0] REG_OVERFLOW_HI = 32'h014;
    localparam logic [31:0] REG_EVSEL_BASE  = 32'h100;
    localparam logic [31:0] REG_COUNTER_BASE = 32'h200;
    // Clearing bits 7:2 maps any indexed register onto its bank base.
    localparam logic [31:0] REG_INDEX_MASK  = 32'hFFFF_FF03;

    localparam int unsigned CTRL_ENABLE_COUNTERS = 0;
    localparam int unsigned CTRL_ENABLE_PREFETCH = 1;
    localparam int unsigned CTRL_SATURATE        = 2;
    localparam logic [2:0]  CTRL_RESET           = 3'b010;

    localparam int unsigned EV_L1_MISS          = 0;
    localparam int unsigned EV_L1_HIT           = 1;
    localparam int unsigned EV_L1_STALL         = 2;
    localparam int unsigned EV_L1_HANDLER_STALL = 3;
    localparam int unsigned EV_L0_BASE          = 4;
    localparam int unsigned EV_PER_PORT         = 5;
    localparam int unsigned EV_L0_MISS          = 0;
    localparam int unsigned EV_L0_HIT           = 1;
    localparam int unsigned EV_L0_PREFETCH      = 2;
    localparam int unsigned EV_L0_DOUBLE_HIT    = 3;
    localparam int unsigned EV_L0_STALL         = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } perf_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } perf_reg_rsp_t;

    function automatic int unsigned num_events(input int unsigned nr_fetch_ports);
        return EV_L0_BASE + EV_PER_PORT * nr_fetch_ports;
    endfunction

endpackage

// File: rtl/snitch_icache_pkg.sv
// Event pulse bundles exported by the L0 fetch ports and the shared L1 instruction cache.
package snitch_icache_pkg;

    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
        logic l0_stall;
    } icache_l0_events_t;

    typedef struct packed {
        logic l1_miss;
        logic l1_hit;
        logic l1_stall;
        logic l1_handler_stall;
    } icache_l1_events_t;

endpackage

// File: rtl/cluster_icache_perf_counter.sv
// One programmable event counter with wrap/saturate behaviour and an overflow pulse.
module cluster_icache_perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] ld_val,
    input  logic                 sat,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 overflow
);

    logic at_max;

    assign at_max   = &value;
    assign overflow = inc & at_max & ~clear & ~load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= ld_val;
        end else if (inc) begin
            if (!at_max) begin
                value <= value + CNT_WIDTH'(1);
            end else if (!sat) begin
                value <= '0;
            end
        end
    end

endmodule

// File: rtl/cluster_icache_perf_ctrl.sv
// Instruction cache control/performance block: prefetch enable, per-port flush handshake
// and a bank of programmable event counters behind a 32-bit register bus.
module cluster_icache_perf_ctrl
    import cluster_icache_perf_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 1,
    parameter int unsigned NUM_COUNTERS   = 8,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter type reg_req_t = cluster_icache_perf_pkg::perf_reg_req_t,
    parameter type reg_rsp_t = cluster_icache_perf_pkg::perf_reg_rsp_t
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  reg_req_t                                              reg_req_i,
    output reg_rsp_t                                              reg_rsp_o,
    output logic                                                  enable_prefetching_o,
    output logic [NR_FETCH_PORTS-1:0]                             flush_valid_o,
    input  logic [NR_FETCH_PORTS-1:0]                             flush_ready_i,
    input  snitch_icache_pkg::icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
    input  snitch_icache_pkg::icache_l1_events_t                  l1_events_i
);

    localparam int unsigned NumEvents = num_events(NR_FETCH_PORTS);
    localparam int unsigned IdxW      = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

    logic [31:0]               addr;
    logic [31:0]               wdata;
    logic [5:0]                idx;
    logic [IdxW-1:0]           idx_sel;
    logic                      idx_ok;
    logic                      wr;

    logic [2:0]                ctrl_q;
    logic [NR_FETCH_PORTS-1:0] pending_q, pending_d, flush_set;
    logic [NUM_COUNTERS-1:0]   ovf_q, ovf_d, ovf_set;
    logic [63:0]               ovf_ext, ovf_w1c;
    logic [7:0]                evsel_q [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]      cnt_val [NUM_COUNTERS];
    logic [NumEvents-1:0]      events;
    logic [255:0]              events_ext;

    logic hit_ctrl, hit_flush, hit_sel_flush, hit_clear, hit_ovf_lo, hit_ovf_hi;
    logic hit_evsel, hit_counter, mapped;
    logic [31:0] rdata;
    logic clear_all;

    assign addr    = reg_req_i.addr;
    assign wdata   = reg_req_i.wdata;
    assign idx     = addr[7:2];
    assign idx_sel = addr[2 +: IdxW];
    assign idx_ok  = ({26'b0, idx} < NUM_COUNTERS);
    // Partial-strobe writes are dropped silently; they are not a bus error.
    assign wr      = reg_req_i.valid & reg_req_i.write & (reg_req_i.wstrb == 4'hF);

    assign events[EV_L1_MISS]          = l1_events_i.l1_miss;
    assign events[EV_L1_HIT]           = l1_events_i.l1_hit;
    assign events[EV_L1_STALL]         = l1_events_i.l1_stall;
    assign events[EV_L1_HANDLER_STALL] = l1_events_i.l1_handler_stall;

    for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_port_events
        localparam int unsigned Base = EV_L0_BASE + EV_PER_PORT * p;
        assign events[Base + EV_L0_MISS]       = l0_events_i[p].l0_miss;
        assign events[Base + EV_L0_HIT]        = l0_events_i[p].l0_hit;
        assign events[Base + EV_L0_PREFETCH]   = l0_events_i[p].l0_prefetch;
        assign events[Base + EV_L0_DOUBLE_HIT] = l0_events_i[p].l0_double_hit;
        assign events[Base + EV_L0_STALL]      = l0_events_i[p].l0_stall;
    end

    // Zero padding makes every select at or above NumEvents count nothing.
    always_comb begin
        events_ext = '0;
        events_ext[NumEvents-1:0] = events;
    end

    always_comb begin
        ovf_ext = '0;
        ovf_ext[NUM_COUNTERS-1:0] = ovf_q;
    end

    always_comb begin
        hit_ctrl      = (addr == REG_CTRL);
        hit_flush     = (addr == REG_FLUSH);
        hit_sel_flush = (addr == REG_SEL_FLUSH);
        hit_clear     = (addr == REG_CLEAR);
        hit_ovf_lo    = (addr == REG_OVERFLOW_LO);
        hit_ovf_hi    = (addr == REG_OVERFLOW_HI);
        hit_evsel     = ((addr & REG_INDEX_MASK) == REG_EVSEL_BASE) && idx_ok;
        hit_counter   = ((addr & REG_INDEX_MASK) == REG_COUNTER_BASE) && idx_ok;
        mapped        = hit_ctrl | hit_flush | hit_sel_flush | hit_clear |
                        hit_ovf_lo | hit_ovf_hi | hit_evsel | hit_counter;

        rdata = '0;
        if (hit_ctrl)      rdata[2:0] = ctrl_q;
        if (hit_flush)     rdata[0] = |pending_q;
        if (hit_sel_flush) rdata[NR_FETCH_PORTS-1:0] = pending_q;
        if (hit_ovf_lo)    rdata = ovf_ext[31:0];
        if (hit_ovf_hi)    rdata = ovf_ext[63:32];
        if (hit_evsel)     rdata[7:0] = evsel_q[idx_sel];
        if (hit_counter)   rdata[CNT_WIDTH-1:0] = cnt_val[idx_sel];
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = reg_req_i.valid & ~mapped;
    end

    assign clear_all = wr & hit_clear & wdata[0];

    always_comb begin
        flush_set = '0;
        if (wr && hit_flush && wdata[0]) flush_set = '1;
        if (wr && hit_sel_flush)         flush_set = flush_set | wdata[NR_FETCH_PORTS-1:0];
    end

    // A set in the same cycle as a handshake wins, keeping valid asserted.
    assign pending_d = (pending_q & ~flush_ready_i) | flush_set;

    always_comb begin
        ovf_w1c = '0;
        if (wr && hit_ovf_lo) ovf_w1c[31:0]  = wdata;
        if (wr && hit_ovf_hi) ovf_w1c[63:32] = wdata;
        if (clear_all) ovf_d = '0;
        else           ovf_d = (ovf_q & ~ovf_w1c[NUM_COUNTERS-1:0]) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= CTRL_RESET;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            if (wr && hit_ctrl) ctrl_q <= wdata[2:0];
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_counter
        localparam logic [7:0] EvselReset = (i < NumEvents) ? 8'(i) : 8'hFF;
        logic sel_hit;

        assign sel_hit = (idx_sel == IdxW'(i));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                evsel_q[i] <= EvselReset;
            end else if (wr && hit_evsel && sel_hit) begin
                evsel_q[i] <= wdata[7:0];
            end
        end

        cluster_icache_perf_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) i_counter (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .inc      (ctrl_q[CTRL_ENABLE_COUNTERS] & events_ext[evsel_q[i]]),
            .clear    (clear_all),
            .load     (wr & hit_counter & sel_hit),
            .ld_val   (wdata[CNT_WIDTH-1:0]),
            .sat      (ctrl_q[CTRL_SATURATE]),
            .value    (cnt_val[i]),
            .overflow (ovf_set[i])
        );
    end

    assign enable_prefetching_o = ctrl_q[CTRL_ENABLE_PREFETCH];
    assign flush_valid_o        = pending_q;

endmodule
